// File: rtl/bcd_xs3_word_converter.sv
// Sequential BCD<->Excess-3 word converter, one nibble per clock, LSB digit first.
// Optional saturating error-word counter when BCD_XS3_ERRCNT_EN is defined.

module bcd_xs3_digit (
  input  logic       mode,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       err
);
  always_comb begin
    dout = 4'hF;
    err  = 1'b1;
    if (!mode) begin
      if (din <= 4'd9) begin
        dout = din + 4'd3;
        err  = 1'b0;
      end
    end else begin
      if (din >= 4'd3 && din <= 4'd12) begin
        dout = din - 4'd3;
        err  = 1'b0;
      end
    end
  end
endmodule

module bcd_xs3_word_converter #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic                out_err,
  output logic                busy
`ifdef BCD_XS3_ERRCNT_EN
  ,output logic [7:0]         err_cnt
`endif
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;
  typedef struct packed {
    logic [W-1:0] data;
    logic         mode;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [3:0]       cur_digit, cur_nib;
  logic             cur_err;

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IDX_W'(i)) cur_digit = req_q.data[4*i +: 4];
  end

  bcd_xs3_digit u_digit (
    .mode (req_q.mode),
    .din  (cur_digit),
    .dout (cur_nib),
    .err  (cur_err)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          req_d      = '{data: in_data, mode: in_mode};
          out_data_d = '0;
          out_err_d  = 1'b0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        for (int i = 0; i < DIGITS; i++)
          if (idx_q == IDX_W'(i)) out_data_d[4*i +: 4] = cur_nib;
        out_err_d = out_err_q | cur_err;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        // Result is frozen here; only the consumer handshake moves us on.
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

`ifdef BCD_XS3_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == S_DONE && out_ready && out_err_q && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bcd_xs3_word_converter.sv
// Directed + random bench for bcd_xs3_word_converter with an arithmetic reference model.
module tb_bcd_xs3_word_converter;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         busy;
`ifdef BCD_XS3_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  int errs = 0;
  int checks = 0;
  int exp_errcnt = 0;

  always #5 clk = ~clk;

  bcd_xs3_word_converter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
`ifdef BCD_XS3_ERRCNT_EN
    ,.err_cnt  (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value v maps to v+3 (BCD->XS3); XS3 code c maps to c-3 when it encodes 0..9.
  function automatic void model(input logic [W-1:0] d, input logic m,
                                output logic [W-1:0] o, output logic e);
    o = '0;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int v;
      int r;
      v = int'(d[4*i +: 4]);
      r = m ? v - 3 : v + 3;
      if ((!m && v < 10) || (m && r >= 0 && r < 10)) o[4*i +: 4] = 4'(r);
      else begin
        o[4*i +: 4] = 4'hF;
        e = 1'b1;
      end
    end
  endfunction

  task automatic run_word(input logic [W-1:0] d, input logic m, input int hold, input string tag);
    logic [W-1:0] eo;
    logic         ee;
    int           lat;
    model(d, m, eo, ee);
    @(negedge clk);
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_mode  = 1'($urandom);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      @(posedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(DIGITS));
    check({tag, " out_data"}, 64'(out_data), 64'(eo));
    check({tag, " out_err"}, 64'(out_err), 64'(ee));
    check({tag, " busy_done"}, 64'(busy), 64'd1);
    check({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold_data"}, 64'(out_data), 64'(eo));
      check({tag, " hold_err"}, 64'(out_err), 64'(ee));
      check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (ee && exp_errcnt < 255) exp_errcnt++;
    @(negedge clk);
    check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, " busy_idle"}, 64'(busy), 64'd0);
`ifdef BCD_XS3_ERRCNT_EN
    check({tag, " err_cnt"}, 64'(err_cnt), 64'(exp_errcnt));
`endif
  endtask

  initial begin
    #12;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_err", 64'(out_err), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
`ifdef BCD_XS3_ERRCNT_EN
    check("rst err_cnt", 64'(err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_word(16'h1234, 1'b0, 0, "b2x_1234");
    run_word(16'h4567, 1'b1, 0, "x2b_4567");
    run_word(16'h0909, 1'b0, 0, "b2x_0909");
    run_word(16'h3C3C, 1'b1, 0, "x2b_3c3c");
    run_word(16'h9A00, 1'b0, 0, "b2x_inv");
    run_word(16'h0D33, 1'b1, 0, "x2b_inv");
`ifdef BCD_XS3_ERRCNT_EN
    check("err_cnt_two", 64'(err_cnt), 64'd2);
`endif
    run_word(16'h5678, 1'b0, 10, "backpressure");

    // Async reset while digit index 2 is pending.
    @(negedge clk);
    in_data  = 16'h1234;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_errcnt = 0;
    #1;
    check("arst out_valid", 64'(out_valid), 64'd0);
    check("arst out_data", 64'(out_data), 64'd0);
    check("arst out_err", 64'(out_err), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst in_ready", 64'(in_ready), 64'd1);
`ifdef BCD_XS3_ERRCNT_EN
    check("arst err_cnt", 64'(err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst in_ready", 64'(in_ready), 64'd1);
    run_word(16'h0000, 1'b0, 0, "b2x_0000");

    for (int n = 0; n < 20; n++)
      run_word(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
